// File: rtl/gactx_seq_fetch.sv
// GACT-X sequence fetcher: splits a byte-length sequence into 4 KB-safe AXI4
// read bursts, buffers the returned 512-bit beats and streams them out with
// byte-keep and last markers.
module gactx_seq_fetch #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_BURST_LEN    = 64,
  parameter int C_FIFO_DEPTH       = 64
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   seq_addr,
  input  logic [31:0]                     seq_len,
  output logic                            busy,
  output logic                            done,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                            m_axi_rlast,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   out_data,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] out_keep,
  output logic                            out_last
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int BW = 27;                        // ceil(2^32/64) beats fits in 27 bits
  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = ((CW > 9) ? CW : 9) + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q, araddr_q, addr_d;
  logic [BW-1:0]   left_q, total_q, ld_idx_q, left_d, tot_s;
  logic [5:0]      tail_q;
  logic [CW-1:0]   outst_q, outst_d, mem_cnt_q, mem_cnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]      arlen_q;
  logic            arvalid_q, busy_q, done_q;
  logic            out_valid_q, out_last_q;
  logic [DW-1:0]   out_data_q;
  logic [KW-1:0]   out_keep_q;
  logic [DW-1:0]   mem_q [C_FIFO_DEPTH];
  logic [32:0]     tot_sum_s;
  logic [8:0]      hs_beats_s, nb_s;
  logic            ar_hs_s, push_s, pop_s, load_s, mem_rd_s, mem_wr_s, bypass_s;
  logic            out_valid_d, credit_s, issue_s, last_ld_s, start_acc_s;
  logic            unused_s;

  // Beats in the next burst: bounded by remaining beats, max burst and 4 KB page room
  function automatic logic [8:0] burst_len(input logic [5:0] page_off, input logic [BW-1:0] left);
    logic [8:0] room;
    logic [8:0] b;
    room = 9'd64 - {3'b000, page_off};
    b    = 9'(C_MAX_BURST_LEN);
    if (room < b) b = room;
    if (left < BW'(b)) b = left[8:0];
    return b;
  endfunction

  // Byte enables: full beat except a partial final beat
  function automatic logic [KW-1:0] keep_mask(input logic is_last, input logic [5:0] tail);
    if (is_last && (tail != 6'd0)) return (KW'(1) << tail) - KW'(1);
    else return {KW{1'b1}};
  endfunction

  assign m_axi_rready  = 1'b1;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_keep      = out_keep_q;
  assign out_last      = out_last_q;
  assign unused_s      = m_axi_rlast;

  // Handshake decode, credit check and next-state arithmetic
  always_comb begin
    tot_sum_s   = {1'b0, seq_len} + 33'd63;
    tot_s       = tot_sum_s[32:6];
    start_acc_s = (state_q == S_IDLE) && start;
    ar_hs_s     = arvalid_q && m_axi_arready;
    hs_beats_s  = ar_hs_s ? ({1'b0, arlen_q} + 9'd1) : 9'd0;
    push_s      = m_axi_rvalid && (outst_q != '0);
    pop_s       = out_valid_q && out_ready;
    load_s      = !out_valid_q || pop_s;
    mem_rd_s    = load_s && (mem_cnt_q != '0);
    bypass_s    = load_s && (mem_cnt_q == '0) && push_s;
    mem_wr_s    = push_s && !bypass_s;
    mem_cnt_d   = mem_cnt_q + CW'(mem_wr_s) - CW'(mem_rd_s);
    out_valid_d = load_s ? (mem_rd_s || bypass_s) : 1'b1;
    outst_d     = outst_q + CW'(hs_beats_s) - CW'(push_s);
    addr_d      = addr_q + AW'({hs_beats_s, 6'b000000});
    left_d      = left_q - BW'(hs_beats_s);
    nb_s        = burst_len(addr_d[11:6], left_d);
    credit_s    = (SW'(mem_cnt_d) + SW'(out_valid_d) + SW'(outst_d) + SW'(nb_s)) <= SW'(C_FIFO_DEPTH);
    issue_s     = (left_d != '0) && credit_s;
    last_ld_s   = (ld_idx_q == (total_q - BW'(1)));
  end

  // Control FSM with registered AR channel and status outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      total_q   <= '0;
      tail_q    <= 6'd0;
      outst_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      outst_q <= outst_d;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q  <= seq_addr;
            total_q <= tot_s;
            left_q  <= tot_s;
            tail_q  <= seq_len[5:0];
            if (tot_s == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              arvalid_q <= 1'b1;
              araddr_q  <= seq_addr;
              arlen_q   <= 8'(burst_len(seq_addr[11:6], tot_s) - 9'd1);
            end
          end
        end
        S_RUN: begin
          addr_q <= addr_d;
          left_q <= left_d;
          if (arvalid_q && !m_axi_arready) begin
            arvalid_q <= 1'b1;
          end else if (issue_s) begin
            arvalid_q <= 1'b1;
            araddr_q  <= addr_d;
            arlen_q   <= 8'(nb_s - 9'd1);
          end else begin
            arvalid_q <= 1'b0;
            if (left_d == '0) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop_s && out_last_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and output register; an empty FIFO lets an R beat bypass straight to the output
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      ld_idx_q    <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (mem_wr_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (start_acc_s) ld_idx_q <= '0;
      else if (mem_rd_s || bypass_s) ld_idx_q <= ld_idx_q + BW'(1);
      if (load_s) begin
        out_valid_q <= mem_rd_s || bypass_s;
        if (mem_rd_s) begin
          out_data_q <= mem_q[rd_ptr_q];
          rd_ptr_q   <= rd_ptr_q + PW'(1);
        end else if (bypass_s) begin
          out_data_q <= m_axi_rdata;
        end
        if (mem_rd_s || bypass_s) begin
          out_keep_q <= keep_mask(last_ld_s, tail_q);
          out_last_q <= last_ld_s;
        end
      end
    end
  end

  // Beat storage (data only, no reset needed)
  always_ff @(posedge ap_clk) begin
    if (mem_wr_s) mem_q[wr_ptr_q] <= m_axi_rdata;
  end

endmodule

// File: tb/tb_gactx_seq_fetch.sv
// Self-checking bench for gactx_seq_fetch: AXI read slave model, stream sink
// and scoreboard queues of expected AR requests and output beats.
module tb_gactx_seq_fetch;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  seq_addr = 64'd0;
  logic [31:0]  seq_len = 32'd0;
  logic         busy, done;
  logic         m_axi_arvalid, m_axi_rready;
  logic         m_axi_arready = 1'b0;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_rvalid = 1'b0;
  logic [511:0] m_axi_rdata = 512'd0;
  logic         m_axi_rlast = 1'b0;
  logic         out_valid, out_last;
  logic         out_ready = 1'b0;
  logic [511:0] out_data;
  logic [63:0]  out_keep;

  gactx_seq_fetch dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .seq_addr(seq_addr), .seq_len(seq_len),
    .busy(busy), .done(done),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Slave / sink model state
  logic [63:0]  rq[$];
  logic [63:0]  got_ar_addr[$], exp_ar_addr[$];
  logic [7:0]   got_ar_len[$], exp_ar_len[$];
  logic [511:0] got_data[$], exp_data[$];
  logic [63:0]  got_keep[$], exp_keep[$];
  logic         got_last[$], exp_last[$];
  bit ar_rand = 0, r_rand = 0;
  int or_mode = 1;
  int stray_n = 0, r_limit = 1000000, r_served = 0, req_beats = 0;
  int done_cnt = 0, done_cyc = -1, last_hs_cyc = -2, first_ar_cyc = -1, start_cyc = 0;
  int rready_low = 0, ar_unstable = 0, out_unstable = 0;
  bit ov_seen = 0;
  bit prev_ar_wait = 0, prev_out_wait = 0;
  logic [63:0]  prev_araddr;
  logic [7:0]   prev_arlen;
  logic [511:0] prev_data;
  logic [63:0]  prev_keep;
  logic         prev_last;

  function automatic logic [511:0] beat_data(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = (a + 64'(i)) ^ 64'hC3A5_0F1E_7B2D_9604;
    return d;
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;

  // AXI slave, stream sink and protocol observers; decisions apply to the next rising edge
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (prev_ar_wait && (!m_axi_arvalid || m_axi_araddr !== prev_araddr || m_axi_arlen !== prev_arlen))
        ar_unstable++;
      if (prev_out_wait && (!out_valid || out_data !== prev_data || out_keep !== prev_keep || out_last !== prev_last))
        out_unstable++;
    end
    if (m_axi_rready !== 1'b1) rready_low++;
    if (out_valid) ov_seen = 1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (m_axi_arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
    if (rq.size() > 0 && r_served < r_limit && (!r_rand || $urandom_range(0, 3) != 0)) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = beat_data(rq.pop_front());
      m_axi_rlast  = (rq.size() == 0);
      r_served++;
    end else if (stray_n > 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = {16{32'hDEAD_BEEF}};
      m_axi_rlast  = 1'b1;
      stray_n--;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
    end
    m_axi_arready = !ar_rand || ($urandom_range(0, 2) != 0);
    if (m_axi_arvalid && m_axi_arready) begin
      got_ar_addr.push_back(m_axi_araddr);
      got_ar_len.push_back(m_axi_arlen);
      for (int i = 0; i <= int'(m_axi_arlen); i++) rq.push_back(m_axi_araddr + 64'(64 * i));
      req_beats += int'(m_axi_arlen) + 1;
    end
    out_ready = (or_mode == 1) ? 1'b1 : (or_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
      got_last.push_back(out_last);
      if (out_last) last_hs_cyc = cyc + 1;
    end
    prev_ar_wait  = m_axi_arvalid && !m_axi_arready;
    prev_araddr   = m_axi_araddr;
    prev_arlen    = m_axi_arlen;
    prev_out_wait = out_valid && !out_ready;
    prev_data     = out_data;
    prev_keep     = out_keep;
    prev_last     = out_last;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(negedge ap_clk); #1; end
  endtask

  task automatic clear_sb();
    got_ar_addr.delete(); got_ar_len.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    got_data.delete(); got_keep.delete(); got_last.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -2; first_ar_cyc = -1;
    r_served = 0; req_beats = 0; ov_seen = 0;
  endtask

  task automatic push_exp_ar(input logic [63:0] a, input logic [7:0] l);
    exp_ar_addr.push_back(a);
    exp_ar_len.push_back(l);
  endtask

  task automatic push_exp_beats(input logic [63:0] a, input int len);
    int total, tail;
    logic [63:0] k;
    total = (len + 63) / 64;
    tail = len % 64;
    for (int b = 0; b < total; b++) begin
      k = '1;
      if (b == total - 1 && tail != 0) begin
        k = '0;
        for (int i = 0; i < tail; i++) k[i] = 1'b1;
      end
      exp_data.push_back(beat_data(a + 64'(64 * b)));
      exp_keep.push_back(k);
      exp_last.push_back(b == total - 1);
    end
  endtask

  task automatic start_xfer(input logic [63:0] a, input int len);
    start = 1'b1; seq_addr = a; seq_len = 32'(len);
    start_cyc = cyc + 1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(1); n++; end
    n_checks++;
    if (done_cnt == 0) begin n_fail++; $display("FAIL %s done_timeout waited %0d cycles, required done pulse", name, n); end
  endtask

  task automatic check_done(input string name);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s done_busy got done=%b busy=%b required done=1 busy=0", name, done, busy);
    end
    n_checks++;
    if (done_cyc !== last_hs_cyc) begin
      n_fail++; $display("FAIL %s done_timing got cycle %0d required %0d", name, done_cyc, last_hs_cyc);
    end
    step(1);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got done=%b required 0", name, done); end
  endtask

  task automatic test_reset();
    step(2);
    n_checks++;
    if (m_axi_rready !== 1'b1) begin n_fail++; $display("FAIL reset_rready_in_reset got %b required 1", m_axi_rready); end
    ap_rst_n = 1'b1;
    step(2);
    n_checks++;
    if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== 73'd0) begin
      n_fail++; $display("FAIL reset_ar got arvalid=%b araddr=%h arlen=%h required zeros", m_axi_arvalid, m_axi_araddr, m_axi_arlen);
    end
    n_checks++;
    if ({out_valid, out_data, out_keep, out_last} !== 578'd0) begin
      n_fail++; $display("FAIL reset_out got valid=%b keep=%h last=%b required zeros", out_valid, out_keep, out_last);
    end
    n_checks++;
    if ({busy, done, m_axi_rready} !== 3'b001) begin
      n_fail++; $display("FAIL reset_status got busy=%b done=%b rready=%b required 0 0 1", busy, done, m_axi_rready);
    end
  endtask

  task automatic test_zero_len();
    clear_sb();
    start_xfer(64'h0, 0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_done got done=%b busy=%b required 1 0", done, busy);
    end
    step(1);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_pulse got done=%b busy=%b required 0 0", done, busy);
    end
    step(5);
    n_checks++;
    if (got_ar_addr.size() != 0 || got_data.size() != 0 || done_cnt != 1 || first_ar_cyc != -1) begin
      n_fail++; $display("FAIL zero_len_quiet got ars=%0d beats=%0d dones=%0d required 0 0 1", got_ar_addr.size(), got_data.size(), done_cnt);
    end
  endtask

  task automatic test_basic();
    logic [63:0] ga, ea;
    logic [7:0]  gl, el;
    clear_sb();
    push_exp_ar(64'h1000, 8'd1);
    push_exp_beats(64'h1000, 100);
    start_xfer(64'h1000, 100);
    n_checks++;
    if (first_ar_cyc !== start_cyc || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_first_ar got cycle %0d busy=%b required cycle %0d busy=1", first_ar_cyc, busy, start_cyc);
    end
    wait_done("basic", 200);
    check_done("basic");
    n_checks++;
    if (got_ar_addr.size() != exp_ar_addr.size()) begin
      n_fail++; $display("FAIL basic_ar_count got %0d required %0d", got_ar_addr.size(), exp_ar_addr.size());
    end
    while (exp_ar_addr.size() > 0 && got_ar_addr.size() > 0) begin
      ga = got_ar_addr.pop_front(); gl = got_ar_len.pop_front();
      ea = exp_ar_addr.pop_front(); el = exp_ar_len.pop_front();
      n_checks++;
      if (ga !== ea || gl !== el) begin n_fail++; $display("FAIL basic_ar got %h/%0d required %h/%0d", ga, gl, ea, el); end
    end
    n_checks++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL basic_beat_count got %0d required %0d", got_data.size(), exp_data.size());
    end
    while (exp_data.size() > 0 && got_data.size() > 0) begin
      n_checks++;
      if (got_data[0] !== exp_data[0] || got_keep[0] !== exp_keep[0] || got_last[0] !== exp_last[0]) begin
        n_fail++; $display("FAIL basic_beat got keep=%h last=%b required keep=%h last=%b", got_keep[0], got_last[0], exp_keep[0], exp_last[0]);
      end
      void'(got_data.pop_front()); void'(got_keep.pop_front()); void'(got_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
    end
  endtask

  task automatic test_4k_split();
    logic [63:0] ga, ea;
    logic [7:0]  gl, el;
    clear_sb();
    ar_rand = 1; r_rand = 1; or_mode = 2;
    ar_unstable = 0; out_unstable = 0;
    push_exp_ar(64'h0FC0, 8'd0);
    push_exp_ar(64'h1000, 8'd2);
    push_exp_beats(64'h0FC0, 256);
    start_xfer(64'h0FC0, 256);
    wait_done("split4k", 400);
    check_done("split4k");
    ar_rand = 0; r_rand = 0; or_mode = 1;
    n_checks++;
    if (got_ar_addr.size() != exp_ar_addr.size()) begin
      n_fail++; $display("FAIL split4k_ar_count got %0d required %0d", got_ar_addr.size(), exp_ar_addr.size());
    end
    while (exp_ar_addr.size() > 0 && got_ar_addr.size() > 0) begin
      ga = got_ar_addr.pop_front(); gl = got_ar_len.pop_front();
      ea = exp_ar_addr.pop_front(); el = exp_ar_len.pop_front();
      n_checks++;
      if (ga !== ea || gl !== el) begin n_fail++; $display("FAIL split4k_ar got %h/%0d required %h/%0d", ga, gl, ea, el); end
    end
    n_checks++;
    if (got_data.size() != exp_data.size()) begin
      n_fail++; $display("FAIL split4k_beat_count got %0d required %0d", got_data.size(), exp_data.size());
    end
    while (exp_data.size() > 0 && got_data.size() > 0) begin
      n_checks++;
      if (got_data[0] !== exp_data[0] || got_keep[0] !== exp_keep[0] || got_last[0] !== exp_last[0]) begin
        n_fail++; $display("FAIL split4k_beat got data=%h required %h", got_data[0][63:0], exp_data[0][63:0]);
      end
      void'(got_data.pop_front()); void'(got_keep.pop_front()); void'(got_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
    end
    n_checks++;
    if (ar_unstable != 0 || out_unstable != 0) begin
      n_fail++; $display("FAIL split4k_stability got ar=%0d out=%0d changes while stalled required 0 0", ar_unstable, out_unstable);
    end
  endtask

  task automatic test_backpressure();
    int nbeat, bad;
    logic [63:0] ga;
    logic [7:0]  gl;
    clear_sb();
    rready_low = 0;
    or_mode = 0;
    for (int i = 0; i < 4; i++) push_exp_ar(64'h20000 + 64'(i * 4096), 8'd63);
    push_exp_beats(64'h20000, 16384);
    start_xfer(64'h20000, 16384);
    step(300);
    n_checks++;
    if (req_beats != 64 || got_ar_addr.size() != 1 || m_axi_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_credit got %0d beats in %0d ARs arvalid=%b required 64 in 1 arvalid=0", req_beats, got_ar_addr.size(), m_axi_arvalid);
    end
    or_mode = 1;
    wait_done("backpressure", 5000);
    check_done("backpressure");
    n_checks++;
    if (got_ar_addr.size() != 4) begin n_fail++; $display("FAIL backpressure_ar_count got %0d required 4", got_ar_addr.size()); end
    while (exp_ar_addr.size() > 0 && got_ar_addr.size() > 0) begin
      ga = got_ar_addr.pop_front(); gl = got_ar_len.pop_front();
      n_checks++;
      if (ga !== exp_ar_addr[0] || gl !== exp_ar_len[0]) begin
        n_fail++; $display("FAIL backpressure_ar got %h/%0d required %h/%0d", ga, gl, exp_ar_addr[0], exp_ar_len[0]);
      end
      void'(exp_ar_addr.pop_front()); void'(exp_ar_len.pop_front());
    end
    nbeat = got_data.size();
    bad = 0;
    while (exp_data.size() > 0 && got_data.size() > 0) begin
      if (got_data[0] !== exp_data[0] || got_keep[0] !== exp_keep[0] || got_last[0] !== exp_last[0]) bad++;
      void'(got_data.pop_front()); void'(got_keep.pop_front()); void'(got_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
    end
    n_checks++;
    if (nbeat != 256 || bad != 0) begin
      n_fail++; $display("FAIL backpressure_beats got %0d beats with %0d wrong required 256 with 0 wrong", nbeat, bad);
    end
    n_checks++;
    if (rready_low != 0) begin n_fail++; $display("FAIL backpressure_rready got %0d low cycles required 0", rready_low); end
  endtask

  task automatic test_start_ignored();
    int nbeat, bad;
    clear_sb();
    push_exp_beats(64'h3000, 200);
    start_xfer(64'h3000, 200);
    start_xfer(64'h8000, 64);
    step(2);
    start_xfer(64'h9000, 640);
    wait_done("start_ignored", 300);
    check_done("start_ignored");
    n_checks++;
    if (got_ar_addr.size() != 1 || got_ar_addr[0] !== 64'h3000 || got_ar_len[0] !== 8'd3) begin
      n_fail++; $display("FAIL start_ignored_ar got %0d ARs first=%h required 1 AR 0x3000 len 3", got_ar_addr.size(), got_ar_addr.size() > 0 ? got_ar_addr[0] : 64'hX);
    end
    nbeat = got_data.size();
    bad = 0;
    while (exp_data.size() > 0 && got_data.size() > 0) begin
      if (got_data[0] !== exp_data[0] || got_keep[0] !== exp_keep[0] || got_last[0] !== exp_last[0]) bad++;
      void'(got_data.pop_front()); void'(got_keep.pop_front()); void'(got_last.pop_front());
      void'(exp_data.pop_front()); void'(exp_keep.pop_front()); void'(exp_last.pop_front());
    end
    n_checks++;
    if (nbeat != 4 || bad != 0) begin
      n_fail++; $display("FAIL start_ignored_beats got %0d beats with %0d wrong required 4 with 0 wrong", nbeat, bad);
    end
    step(10);
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_ignored_idle got dones=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_sb();
    or_mode = 0;
    r_limit = 30;
    start_xfer(64'h40000, 2560);
    n = 0;
    while (r_served < 30 && n < 200) begin step(1); n++; end
    step(3);
    n_checks++;
    if (rq.size() != 10 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_setup got %0d beats pending busy=%b required 10 busy=1", rq.size(), busy);
    end
    ap_rst_n = 1'b0;
    step(2);
    n_checks++;
    if ({out_valid, busy, done, m_axi_arvalid, m_axi_rready} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_mid_in_reset got valid=%b busy=%b done=%b arvalid=%b rready=%b required 0 0 0 0 1", out_valid, busy, done, m_axi_arvalid, m_axi_rready);
    end
    rq.delete();
    r_limit = 1000000;
    ap_rst_n = 1'b1;
    or_mode = 1;
    stray_n = 5;
    clear_sb();
    step(20);
    n_checks++;
    if (ov_seen !== 1'b0 || got_data.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_stray got out_valid_seen=%b beats=%0d busy=%b required 0 0 0", ov_seen, got_data.size(), busy);
    end
    clear_sb();
    push_exp_beats(64'h5000, 64);
    start_xfer(64'h5000, 64);
    wait_done("reset_mid_restart", 200);
    check_done("reset_mid_restart");
    n_checks++;
    if (got_ar_addr.size() != 1 || got_ar_addr[0] !== 64'h5000 || got_ar_len[0] !== 8'd0) begin
      n_fail++; $display("FAIL reset_mid_restart_ar got %0d ARs required 1 AR 0x5000 len 0", got_ar_addr.size());
    end
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== exp_data[0] || got_keep[0] !== exp_keep[0] || got_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_restart_beat got %0d beats required 1 full last beat", got_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_basic();
    test_4k_split();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
